// File: rtl/hd_operand_sequencer_if.sv
// rtl/hd_operand_sequencer_if.sv - operand input stream and result output stream of the hd sequencer
interface hd_operand_sequencer_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/hd_operand_sequencer.sv
// rtl/hd_operand_sequencer.sv - assembles A/B operands for the hd kernel, holds x for an eval window, queues y results
module hd_operand_sequencer #(
    parameter int KERNEL_LAT = 1,
    parameter int OUT_DEPTH  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    hd_operand_sequencer_if.slave   io,
    output logic [15:0]             x,
    input  logic [7:0]              y,
    output logic                    busy
);
    localparam int AW = $clog2(OUT_DEPTH);

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        EVAL,
        CAPTURE
    } state_t;

    state_t         state;
    logic [3:0]     cnt;
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic [AW:0]    rd_next;
    logic [7:0]     mem [OUT_DEPTH];
    logic           full;
    logic           empty;
    logic           pop;
    logic           push;
    logic           in_fire;

    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_next     = rd_ptr + (AW+1)'(1);
    assign io.in_ready = !rst && ((state == LOAD_A) || (state == LOAD_B));
    assign in_fire     = io.in_valid && io.in_ready;
    assign pop         = io.out_ready && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO does not block the push.
    assign push        = (state == CAPTURE) && (!full || pop);
    assign io.out_valid = !empty;
    assign busy        = (state != LOAD_A) || !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= LOAD_A;
            cnt         <= 4'd0;
            x           <= 16'h0000;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            io.out_data <= 8'h00;
        end else begin
            case (state)
                LOAD_A: begin
                    if (in_fire) begin
                        x[7:0] <= io.in_data;
                        state  <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (in_fire) begin
                        x[15:8] <= io.in_data;
                        cnt     <= 4'(KERNEL_LAT - 1);
                        state   <= EVAL;
                    end
                end
                EVAL: begin
                    if (cnt == 4'd0) begin
                        state <= CAPTURE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                CAPTURE: begin
                    if (push) begin
                        state <= LOAD_A;
                    end
                end
                default: state <= LOAD_A;
            endcase

            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end

            // out_data always tracks the entry that will be at the head after this edge.
            if (pop) begin
                rd_ptr <= rd_next;
                if (push && (wr_ptr == rd_next)) begin
                    io.out_data <= y;
                end else begin
                    io.out_data <= mem[rd_next[AW-1:0]];
                end
            end else if (push && empty) begin
                io.out_data <= y;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= y;
        end
    end
endmodule
